// File: rtl/phase_decoder.sv
// rtl/phase_decoder.sv - recovers oscillation phase by timing rising edges against full_tick
module phase_decoder #(
  parameter int PHASE_W   = 4,
  parameter int SLOT_LOG2 = 2,
  parameter int STABLE_N  = 3
) (
  input  logic               sclk,
  input  logic               re,
  input  logic               full_tick,
  input  logic               osc_in,
  output logic [PHASE_W-1:0] phi_out,
  output logic               phi_valid,
  output logic               locked,
  output logic               miss,
  output logic               glitch
);

  localparam int CNT_W = PHASE_W + SLOT_LOG2;
  localparam logic [3:0] STAB_MAX = 4'(STABLE_N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               osc_d_q;
  logic [PHASE_W-1:0] cap_q;
  logic               seen_q;
  logic               extra_q;
  logic [3:0]         stab_q;

  logic               rise;
  logic [3:0]         stab_inc;
  logic [3:0]         stab_d;

  assign rise = osc_in & ~osc_d_q;

  // Stability count the closing period would leave behind; stab_q==0 means no valid predecessor
  always_comb begin
    stab_inc = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
    stab_d   = 4'd0;
    if (seen_q) begin
      if ((cap_q == phi_out) && (stab_q != 4'd0)) begin
        stab_d = stab_inc;
      end else begin
        stab_d = 4'd1;
      end
    end
  end

  // Period counter resynced by full_tick, plus one-cycle history of osc_in for edge detection
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      cnt_q   <= '0;
      osc_d_q <= 1'b0;
    end else begin
      cnt_q   <= full_tick ? '0 : cnt_q + 1'b1;
      osc_d_q <= osc_in;
    end
  end

  // Capture/close FSM with registered result and strobe outputs
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      seen_q    <= 1'b0;
      extra_q   <= 1'b0;
      stab_q    <= 4'd0;
      phi_out   <= '0;
      phi_valid <= 1'b0;
      locked    <= 1'b0;
      miss      <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      phi_valid <= 1'b0;
      miss      <= 1'b0;
      glitch    <= 1'b0;
      if (full_tick) begin
        // Close the running period with the flags gathered before this cycle
        if (state_q != IDLE) begin
          if (seen_q) begin
            phi_out   <= cap_q;
            phi_valid <= 1'b1;
            glitch    <= extra_q;
          end else begin
            miss <= 1'b1;
          end
          stab_q <= stab_d;
          locked <= (stab_d == STAB_MAX);
        end
        // An edge coincident with the tick opens the new period at phase 0
        extra_q <= 1'b0;
        if (rise) begin
          seen_q  <= 1'b1;
          cap_q   <= '0;
          state_q <= CAPTURED;
        end else begin
          seen_q  <= 1'b0;
          state_q <= ARMED;
        end
      end else begin
        case (state_q)
          ARMED: begin
            if (rise) begin
              cap_q   <= cnt_q[CNT_W-1 -: PHASE_W];
              seen_q  <= 1'b1;
              state_q <= CAPTURED;
            end
          end
          CAPTURED: begin
            if (rise) begin
              extra_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_decoder.sv
// tb/tb_phase_decoder.sv - directed self-checking bench for phase_decoder
module tb_phase_decoder;

  logic       sclk = 1'b0;
  logic       re = 1'b1;
  logic       full_tick = 1'b0;
  logic       osc_in = 1'b0;
  logic [3:0] phi_out;
  logic       phi_valid;
  logic       locked;
  logic       miss;
  logic       glitch;

  int total = 0;
  int bad = 0;

  phase_decoder #(.PHASE_W(4), .SLOT_LOG2(2), .STABLE_N(3)) dut (
    .sclk      (sclk),
    .re        (re),
    .full_tick (full_tick),
    .osc_in    (osc_in),
    .phi_out   (phi_out),
    .phi_valid (phi_valid),
    .locked    (locked),
    .miss      (miss),
    .glitch    (glitch)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  // Tick cycle (optionally with a coincident edge), then check the closed-period results
  task automatic tick(input bit edge_now, input string tag,
                      input logic [3:0] e_phi, input bit e_val, input bit e_lock,
                      input bit e_miss, input bit e_glitch);
    full_tick = 1'b1;
    osc_in    = edge_now;
    cyc();
    full_tick = 1'b0;
    chk({tag, ".phi"},    32'(phi_out),   32'(e_phi));
    chk({tag, ".valid"},  32'(phi_valid), 32'(e_val));
    chk({tag, ".locked"}, 32'(locked),    32'(e_lock));
    chk({tag, ".miss"},   32'(miss),      32'(e_miss));
    chk({tag, ".glitch"}, 32'(glitch),    32'(e_glitch));
  endtask

  // Cycles 1..63 of a period; osc_in pulses high for one cycle at cycle e1 and e2 (cnt = cycle-1)
  task automatic body(input int e1, input int e2, input string tag);
    for (int k = 1; k < 64; k++) begin
      osc_in = (k == e1) || (k == e2);
      cyc();
      if (k == 1) begin
        chk({tag, ".valid_width"},  32'(phi_valid), 32'd0);
        chk({tag, ".miss_width"},   32'(miss),      32'd0);
        chk({tag, ".glitch_width"}, 32'(glitch),    32'd0);
      end
    end
    osc_in = 1'b0;
  endtask

  initial begin
    #1;
    re = 1'b1;
    repeat (3) cyc();
    chk("rst.phi",    32'(phi_out),   32'd0);
    chk("rst.valid",  32'(phi_valid), 32'd0);
    chk("rst.locked", 32'(locked),    32'd0);
    chk("rst.miss",   32'(miss),      32'd0);
    chk("rst.glitch", 32'(glitch),    32'd0);

    // Partial period before the first tick: edges ignored
    re = 1'b0;
    for (int k = 0; k < 10; k++) begin
      osc_in = (k == 5);
      cyc();
    end
    osc_in = 1'b0;

    // First tick only arms; no strobes
    tick(1'b0, "start", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p1");
    tick(1'b0, "c1", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p2");
    tick(1'b0, "c2", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p3");
    tick(1'b0, "c3_lock", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // Missing edge drops lock, phase held
    body(-1, -1, "p4");
    tick(1'b0, "miss", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    body(21, -1, "p5");
    tick(1'b0, "re1", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p6");
    tick(1'b0, "re2", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p7");
    tick(1'b0, "re3_lock", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // Phase change to cnt=40 -> phase 10
    body(41, -1, "p8");
    tick(1'b0, "chg1", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    body(41, -1, "p9");
    tick(1'b0, "chg2", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    body(41, -1, "p10");
    tick(1'b0, "chg3_lock", 4'd10, 1'b1, 1'b1, 1'b0, 1'b0);

    // Two edges at cnt=8 and cnt=30 -> phase 2 with glitch
    body(9, 31, "p11");
    tick(1'b0, "glitch", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);

    // Slot boundaries
    body(4, -1, "p12");
    tick(1'b0, "cnt3", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    body(5, -1, "p13");
    tick(1'b0, "cnt4", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    body(63, -1, "p14");
    tick(1'b0, "cnt62", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);

    // Edge coincident with tick: old period (no edge) misses, new one captures phase 0
    body(-1, -1, "p15");
    tick(1'b1, "coinc_close", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    body(-1, -1, "p16");
    tick(1'b0, "coinc_phase", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Lock again at phase 0 so the async reset has something to clear
    body(1, -1, "p17");
    tick(1'b0, "z2", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    body(1, -1, "p18");
    tick(1'b0, "z3_lock", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Mid-period reset clears outputs without a clock edge
    for (int k = 1; k < 30; k++) begin
      osc_in = (k == 21);
      cyc();
    end
    osc_in = 1'b0;
    re = 1'b1;
    #1;
    chk("mid_rst.locked", 32'(locked),    32'd0);
    chk("mid_rst.phi",    32'(phi_out),   32'd0);
    chk("mid_rst.valid",  32'(phi_valid), 32'd0);
    cyc();
    re = 1'b0;
    repeat (5) cyc();
    tick(1'b0, "rst_start", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    body(21, -1, "p19");
    tick(1'b0, "rst_c1", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
